home_automation_arbiter: RTL and testbench

- Parametrised successor to the fixed 7-state home-automation controller.
- Services N door/fire/window sensor channels plus heater and cooler requests.
- Arbitration is round-robin with a minimum dwell time per serviced event, a preemptive priority channel, and temperature hysteresis.
- Drives one-hot actuator outputs and a state code for the display/status logic.

---
 rtl/home_automation_arbiter.sv | 134 +++++++++++++
 tb/tb_home_automation_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/home_automation_arbiter.sv
// Round-robin home-automation arbiter with dwell, fire preemption
// and temperature hysteresis for the heater/cooler requests.
module home_automation_arbiter #(
    parameter int NUM_SENSORS = 4,
    parameter int TEMP_W      = 6,
    parameter int HEAT_TH     = 16,
    parameter int COOL_TH     = 32,
    parameter int HYST        = 2,
    parameter int DWELL       = 4,
    parameter int PRIO_CH     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SENSORS-1:0]               sensors,
    input  logic [NUM_SENSORS-1:0]               sensor_en,
    input  logic [TEMP_W-1:0]                    temp,
    output logic [NUM_SENSORS+1:0]               output_signals,
    output logic [$clog2(NUM_SENSORS+3)-1:0]     display,
    output logic [NUM_SENSORS+1:0]               pending
);

    localparam int NR = NUM_SENSORS + 2;
    localparam int GW = $clog2(NR);
    localparam int DW = $clog2(NUM_SENSORS + 3);
    localparam int CW = $clog2(DWELL + 1);

    localparam logic [TEMP_W-1:0] HEAT_LO = TEMP_W'(HEAT_TH);
    localparam logic [TEMP_W-1:0] HEAT_HI = TEMP_W'(HEAT_TH + HYST);
    localparam logic [TEMP_W-1:0] COOL_HI = TEMP_W'(COOL_TH);
    localparam logic [TEMP_W-1:0] COOL_LO = TEMP_W'(COOL_TH - HYST);
    localparam logic [GW-1:0]     PRIO    = GW'(PRIO_CH);
    localparam logic [CW-1:0]     CNT_END = CW'(DWELL - 1);
    localparam logic [GW:0]       NR_W    = (GW+1)'(NR);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [CW-1:0]   dwell_cnt;
    logic            heat_req;
    logic            cool_req;

    logic [NR-1:0]   req;
    logic [2*NR-1:0] req2;
    logic [NR-1:0]   rot;
    logic [GW:0]     gp1;
    logic [GW:0]     sum;
    logic [GW-1:0]   off;
    logic [GW-1:0]   low_idx;
    logic [GW-1:0]   rr_idx;

    assign req     = {cool_req, heat_req, sensors & sensor_en};
    assign pending = req;

    // Lowest set request index, used when leaving IDLE
    always_comb begin
        low_idx = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            if (req[k]) low_idx = GW'(k);
        end
    end

    // Rotate req so bit 0 is grant+1, then take the first set bit
    always_comb begin
        req2 = {req, req};
        gp1  = {1'b0, grant} + (GW+1)'(1);
        rot  = NR'(req2 >> gp1);
        off  = '0;
        for (int k = NR - 1; k >= 0; k--) begin
            if (rot[k]) off = GW'(k);
        end
        sum    = gp1 + {1'b0, off};
        rr_idx = (sum >= NR_W) ? GW'(sum - NR_W) : GW'(sum);
    end

    // Temperature hysteresis for heater and cooler requests
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            heat_req <= 1'b0;
            cool_req <= 1'b0;
        end else begin
            if (temp < HEAT_LO)       heat_req <= 1'b1;
            else if (temp >= HEAT_HI) heat_req <= 1'b0;
            if (temp >= COOL_HI)      cool_req <= 1'b1;
            else if (temp < COOL_LO)  cool_req <= 1'b0;
        end
    end

    // Arbitration FSM: dwell, preemption, round-robin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            dwell_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= ACTIVE;
                        grant     <= low_idx;
                        dwell_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    if (req[PRIO_CH] && grant != PRIO) begin
                        grant     <= PRIO;
                        dwell_cnt <= '0;
                    end else if (dwell_cnt < CNT_END) begin
                        dwell_cnt <= dwell_cnt + CW'(1);
                    end else if (|req) begin
                        grant     <= rr_idx;
                        dwell_cnt <= '0;
                    end else begin
                        state     <= IDLE;
                        dwell_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode directly from state so reset clears them at once
    always_comb begin
        output_signals = '0;
        display        = '0;
        if (state == ACTIVE) begin
            output_signals        = '0;
            output_signals[grant] = 1'b1;
            display               = DW'(grant) + DW'(1);
        end
    end

endmodule

// File: tb/tb_home_automation_arbiter.sv
// Bench for home_automation_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_home_automation_arbiter;

    localparam int NS      = 4;
    localparam int NR      = NS + 2;
    localparam int HEAT_TH = 16;
    localparam int COOL_TH = 32;
    localparam int HYST    = 2;
    localparam int DWELL   = 4;
    localparam int PRIO_CH = 2;

    logic          clk;
    logic          rst;
    logic [NS-1:0] sensors;
    logic [NS-1:0] sensor_en;
    logic [5:0]    temp;
    logic [NR-1:0] output_signals;
    logic [2:0]    display;
    logic [NR-1:0] pending;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    home_automation_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .sensors        (sensors),
        .sensor_en      (sensor_en),
        .temp           (temp),
        .output_signals (output_signals),
        .display        (display),
        .pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit active;
        int grant;
        int cnt;
        bit heat;
        bit cool;
    } m_t;

    m_t m;

    function automatic m_t step(m_t s, logic [NS-1:0] sen,
                                logic [NS-1:0] en, int t);
        m_t n;
        logic [NR-1:0] r;
        int j;
        n = s;
        r = {s.cool, s.heat, sen & en};
        if (t < HEAT_TH) n.heat = 1;
        else if (t >= HEAT_TH + HYST) n.heat = 0;
        if (t >= COOL_TH) n.cool = 1;
        else if (t < COOL_TH - HYST) n.cool = 0;
        if (!s.active) begin
            if (r != 0) begin
                n.active = 1;
                n.cnt = 0;
                for (int i = NR - 1; i >= 0; i--)
                    if (r[i]) n.grant = i;
            end
        end else if (r[PRIO_CH] && s.grant != PRIO_CH) begin
            n.grant = PRIO_CH;
            n.cnt = 0;
        end else if (s.cnt < DWELL - 1) begin
            n.cnt = s.cnt + 1;
        end else begin
            n.active = 0;
            n.cnt = 0;
            for (int k = NR; k >= 1; k--) begin
                j = (s.grant + k) % NR;
                if (r[j]) begin
                    n.grant = j;
                    n.active = 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '{0, 0, 0, 0, 0};
        else m <= step(m, sensors, sensor_en, int'(temp));
    end

    task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [NR-1:0] eo;
        logic [NR-1:0] ep;
        int ed;
        if (cmp_en) begin
            eo = '0;
            ed = 0;
            if (m.active) begin
                eo[m.grant] = 1'b1;
                ed = m.grant + 1;
            end
            ep = {m.cool, m.heat, sensors & sensor_en};
            lit("model_out", 32'(output_signals), 32'(eo));
            lit("model_disp", 32'(display), 32'(ed));
            lit("model_pend", 32'(pending), 32'(ep));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int tv;
        rst = 1'b0;
        sensors = '0;
        sensor_en = '1;
        temp = 6'd24;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        cmp_en = 1;
        @(negedge clk);
        lit("rst_out", 32'(output_signals), 32'h0);
        lit("rst_disp", 32'(display), 32'h0);
        lit("rst_pend", 32'(pending), 32'h0);
        repeat (3) tick;

        // two sensors alternate every DWELL cycles
        tick;
        sensors = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            tick;
            @(negedge clk);
            lit("rr_disp", 32'(display), (i < 4) ? 32'd1 : 32'd2);
            lit("rr_out", 32'(output_signals),
                (i < 4) ? 32'h01 : 32'h02);
        end
        tick;
        sensors = '0;
        repeat (10) tick;

        // heater hysteresis
        temp = 6'd15;
        tick;
        @(negedge clk);
        lit("heat_pend", 32'(pending), 32'h10);
        lit("heat_idle", 32'(display), 32'd0);
        tick;
        @(negedge clk);
        lit("heat_disp", 32'(display), 32'd5);
        lit("heat_out", 32'(output_signals), 32'h10);
        tick;
        temp = 6'd17;
        tick;
        @(negedge clk);
        lit("heat_hold", 32'(pending), 32'h10);
        tick;
        temp = 6'd18;
        repeat (8) tick;
        @(negedge clk);
        lit("heat_clr", 32'(pending), 32'h0);
        lit("heat_done", 32'(display), 32'd0);
        tick;
        temp = 6'd24;
        repeat (2) tick;

        // fire preempts sensor 0 mid-dwell
        sensors = 4'b0001;
        tick;
        @(negedge clk);
        lit("pre_d0", 32'(display), 32'd1);
        tick;
        sensors = 4'b0101;
        tick;
        @(negedge clk);
        lit("pre_disp", 32'(display), 32'd3);
        lit("pre_out", 32'(output_signals), 32'h04);
        tick;
        sensors = '0;
        repeat (10) tick;

        // cooler and sensor 3 with wrap-around
        sensors = 4'b1000;
        temp = 6'd40;
        tick;
        @(negedge clk);
        lit("cool_d3", 32'(display), 32'd4);
        lit("cool_pend", 32'(pending), 32'h28);
        repeat (4) tick;
        @(negedge clk);
        lit("cool_disp", 32'(display), 32'd6);
        lit("cool_out", 32'(output_signals), 32'h20);
        repeat (4) tick;
        @(negedge clk);
        lit("wrap_disp", 32'(display), 32'd4);
        repeat (4) tick;
        @(negedge clk);
        lit("cool_again", 32'(display), 32'd6);
        tick;
        sensors = '0;
        rst = 1'b0;
        #1;
        lit("async_out", 32'(output_signals), 32'h0);
        lit("async_disp", 32'(display), 32'h0);
        #1;
        rst = 1'b1;
        tick;
        @(negedge clk);
        lit("rec_pend", 32'(pending), 32'h20);
        lit("rec_idle", 32'(display), 32'd0);
        tick;
        @(negedge clk);
        lit("rec_disp", 32'(display), 32'd6);
        tick;
        temp = 6'd24;
        repeat (8) tick;

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            tick;
            if ($urandom_range(3) == 0) sensors = 4'($urandom);
            if ($urandom_range(15) == 0) sensor_en = 4'($urandom);
            if ($urandom_range(31) == 0) begin
                temp = 6'($urandom);
            end else begin
                tv = int'(temp) + int'($urandom_range(6)) - 3;
                if (tv < 0) tv = 0;
                if (tv > 63) tv = 63;
                temp = 6'(tv);
            end
            if ($urandom_range(299) == 0) begin
                rst = 1'b0;
                #1;
                rst = 1'b1;
            end
        end
        tick;
        @(negedge clk);
        #1;
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
